// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// master drives requests and release; slave (the arbiter) returns the registered grant.
interface rr_grant_arbiter_if #(
  parameter int N     = 8,
  parameter int IDX_W = 3
);
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             timeout;

  modport master (
    output req, done,
    input  grant, grant_idx, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, grant_valid, timeout
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a per-grant hold limit; one-hot grant plus binary index, all registered.
// Latency: req to grant 1 cycle; no backpressure, a grant ends on done, req drop or hold limit.
module rr_grant_arbiter #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input logic              clk,
  input logic              rst,
  rr_grant_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic             grant_valid_q, grant_valid_d;
  logic             timeout_q, timeout_d;

  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] win_idx;
  logic             hold_hit;
  logic             rel_norm;

  // Scan from the highest offset down so the lowest offset from ptr ends up winning.
  always_comb begin
    cand    = '0;
    win_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(N)) begin
        cand = cand - (IDX_W + 1)'(N);
      end
      if (bus.req[cand[IDX_W-1:0]]) begin
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  assign hold_hit = (MAX_HOLD != 0) && (cnt_q == HOLD_W'(MAX_HOLD));
  assign rel_norm = bus.done || !bus.req[grant_idx_q];

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          grant_idx_d      = win_idx;
          grant_valid_d    = 1'b1;
          cnt_d            = HOLD_W'(1);
          state_d          = GRANT;
        end
      end
      GRANT: begin
        if (rel_norm || hold_hit) begin
          grant_d       = '0;
          grant_idx_d   = '0;
          grant_valid_d = 1'b0;
          cnt_d         = '0;
          state_d       = IDLE;
          ptr_d         = (grant_idx_q == IDX_W'(N - 1)) ? '0 : grant_idx_q + IDX_W'(1);
          // A revoke only counts as a timeout when nothing else would have released it.
          timeout_d     = hold_hit && !rel_norm;
        end else begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter with an 8-requester, hold-limit-4 instance.
module tb_rr_grant_arbiter;
  localparam int N = 8;
  localparam int IDX_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [12:0] obs;

  rr_grant_arbiter_if #(.N(N), .IDX_W(IDX_W)) bus ();

  rr_grant_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(4), .HOLD_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout};

  // Expected {grant, grant_idx, grant_valid, timeout}.
  function automatic logic [12:0] expv(input int idx, input bit vld, input bit to);
    logic [7:0] g;
    logic [2:0] gi;
    g  = vld ? (8'h01 << idx) : 8'h00;
    gi = vld ? 3'(idx) : 3'd0;
    return {g, gi, vld, to};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.req  = '0;
    bus.done = 1'b0;
    rst      = 1'b1;
    tick();
    checks++;
    if (obs !== expv(0, 0, 0)) begin
      errors++;
      $display("FAIL reset_hold got=%h want=%h", obs, expv(0, 0, 0));
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== expv(0, 0, 0)) begin
      errors++;
      $display("FAIL reset_idle got=%h want=%h", obs, expv(0, 0, 0));
    end
  endtask

  task automatic test_single();
    bus.req = 8'h04;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (obs !== expv(2, 1, 0)) begin
        errors++;
        $display("FAIL single_grant cyc=%0d got=%h want=%h", c, obs, expv(2, 1, 0));
      end
    end
    bus.done = 1'b1;
    tick();
    checks++;
    if (obs !== expv(0, 0, 0)) begin
      errors++;
      $display("FAIL single_done_release got=%h want=%h", obs, expv(0, 0, 0));
    end
    bus.done = 1'b0;
    bus.req  = 8'h09;
    tick();
    checks++;
    if (obs !== expv(3, 1, 0)) begin
      errors++;
      $display("FAIL single_ptr3 got=%h want=%h", obs, expv(3, 1, 0));
    end
    bus.req = 8'h00;
    tick();
    checks++;
    if (obs !== expv(0, 0, 0)) begin
      errors++;
      $display("FAIL single_req_drop got=%h want=%h", obs, expv(0, 0, 0));
    end
    tick();
    checks++;
    if (obs !== expv(0, 0, 0)) begin
      errors++;
      $display("FAIL single_stay_idle got=%h want=%h", obs, expv(0, 0, 0));
    end
  endtask

  task automatic test_rotation();
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    bus.req = 8'hFF;
    for (int k = 0; k <= 8; k++) begin
      tick();
      checks++;
      if (obs !== expv(k % 8, 1, 0)) begin
        errors++;
        $display("FAIL rot_grant k=%0d got=%h want=%h", k, obs, expv(k % 8, 1, 0));
      end
      bus.done = 1'b1;
      tick();
      checks++;
      if (obs !== expv(0, 0, 0)) begin
        errors++;
        $display("FAIL rot_bubble k=%0d got=%h want=%h", k, obs, expv(0, 0, 0));
      end
      bus.done = 1'b0;
    end
    bus.req = 8'h00;
    tick();
    checks++;
    if (obs !== expv(0, 0, 0)) begin
      errors++;
      $display("FAIL rot_idle got=%h want=%h", obs, expv(0, 0, 0));
    end
  endtask

  task automatic test_timeout();
    bus.req = 8'h01;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (obs !== expv(0, 1, 0)) begin
        errors++;
        $display("FAIL to_hold cyc=%0d got=%h want=%h", c, obs, expv(0, 1, 0));
      end
    end
    tick();
    checks++;
    if (obs !== expv(0, 0, 1)) begin
      errors++;
      $display("FAIL to_pulse got=%h want=%h", obs, expv(0, 0, 1));
    end
    tick();
    checks++;
    if (obs !== expv(0, 1, 0)) begin
      errors++;
      $display("FAIL to_regrant got=%h want=%h", obs, expv(0, 1, 0));
    end
    bus.req = 8'h00;
    tick();
    checks++;
    if (obs !== expv(0, 0, 0)) begin
      errors++;
      $display("FAIL to_idle got=%h want=%h", obs, expv(0, 0, 0));
    end
  endtask

  task automatic test_done_at_limit();
    bus.req = 8'h02;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (obs !== expv(1, 1, 0)) begin
        errors++;
        $display("FAIL lim_hold cyc=%0d got=%h want=%h", c, obs, expv(1, 1, 0));
      end
    end
    bus.done = 1'b1;
    tick();
    checks++;
    if (obs !== expv(0, 0, 0)) begin
      errors++;
      $display("FAIL lim_no_timeout got=%h want=%h", obs, expv(0, 0, 0));
    end
    bus.done = 1'b0;
    bus.req  = 8'h00;
    tick();
    checks++;
    if (obs !== expv(0, 0, 0)) begin
      errors++;
      $display("FAIL lim_idle got=%h want=%h", obs, expv(0, 0, 0));
    end
  endtask

  task automatic test_req_drop();
    bus.req = 8'h60;
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++;
      if (obs !== expv(5, 1, 0)) begin
        errors++;
        $display("FAIL drop_grant5 cyc=%0d got=%h want=%h", c, obs, expv(5, 1, 0));
      end
    end
    bus.req = 8'h40;
    tick();
    checks++;
    if (obs !== expv(0, 0, 0)) begin
      errors++;
      $display("FAIL drop_release got=%h want=%h", obs, expv(0, 0, 0));
    end
    tick();
    checks++;
    if (obs !== expv(6, 1, 0)) begin
      errors++;
      $display("FAIL drop_next6 got=%h want=%h", obs, expv(6, 1, 0));
    end
    bus.req = 8'h00;
    tick();
    checks++;
    if (obs !== expv(0, 0, 0)) begin
      errors++;
      $display("FAIL drop_idle got=%h want=%h", obs, expv(0, 0, 0));
    end
  endtask

  task automatic test_async_reset();
    bus.req = 8'h08;
    tick();
    checks++;
    if (obs !== expv(3, 1, 0)) begin
      errors++;
      $display("FAIL arst_pre got=%h want=%h", obs, expv(3, 1, 0));
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== expv(0, 0, 0)) begin
      errors++;
      $display("FAIL arst_immediate got=%h want=%h", obs, expv(0, 0, 0));
    end
    tick();
    checks++;
    if (obs !== expv(0, 0, 0)) begin
      errors++;
      $display("FAIL arst_held got=%h want=%h", obs, expv(0, 0, 0));
    end
    rst     = 1'b0;
    bus.req = 8'h80;
    tick();
    checks++;
    if (obs !== expv(7, 1, 0)) begin
      errors++;
      $display("FAIL arst_wrap7 got=%h want=%h", obs, expv(7, 1, 0));
    end
    bus.req = 8'h00;
    tick();
    checks++;
    if (obs !== expv(0, 0, 0)) begin
      errors++;
      $display("FAIL arst_idle got=%h want=%h", obs, expv(0, 0, 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req  = '0;
    bus.done = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_done_at_limit();
    test_req_drop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
